// File: rtl/gps_acq_pkg.sv
// Shared types and helpers for the GPS acquisition peak search.
package gps_acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_FLUSH,
        ST_EVAL,
        ST_DONE
    } state_t;

    localparam int CA_LEN     = 1023;
    localparam int CA_PHASE_W = 10;

    // C/A code phase wraps at 1023 chips, so 0 and 1022 are neighbours.
    function automatic logic circ_adjacent(input logic [CA_PHASE_W-1:0] phase_a,
                                           input logic [CA_PHASE_W-1:0] phase_b);
        logic [CA_PHASE_W-1:0] diff;
        diff = (phase_a >= phase_b) ? (phase_a - phase_b) : (phase_b - phase_a);
        return (diff <= CA_PHASE_W'(1)) || (diff == CA_PHASE_W'(CA_LEN - 1));
    endfunction

endpackage

// File: rtl/gps_corr_metric.sv
// Correlator count to saturated absolute deviation from the mid-scale count.
// Latency 1 cycle; no backpressure, flush drops the result being registered.
module gps_corr_metric #(
    parameter int CORR_W  = 12,
    parameter int PHASE_W = 10,
    parameter int BIN_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_vld,
    input  logic [CORR_W-1:0]  in_value,
    input  logic [PHASE_W-1:0] in_phase,
    input  logic [BIN_W-1:0]   in_bin,
    output logic               m_vld,
    output logic [CORR_W-2:0]  m_dat,
    output logic [PHASE_W-1:0] m_phase,
    output logic [BIN_W-1:0]   m_bin
);

    localparam logic [CORR_W-1:0] MID = {1'b1, {(CORR_W-1){1'b0}}};

    logic [CORR_W-1:0]  dev;
    logic               vld_q, vld_d;
    logic [CORR_W-2:0]  dat_q, dat_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [BIN_W-1:0]   bin_q, bin_d;

    always_comb begin
        dev     = (in_value >= MID) ? (in_value - MID) : (MID - in_value);
        vld_d   = in_vld & ~flush;
        dat_d   = dat_q;
        phase_d = phase_q;
        bin_d   = bin_q;
        if (in_vld) begin
            // Only a zero count reaches MID itself; clamp it to the largest metric.
            dat_d   = dev[CORR_W-1] ? '1 : dev[CORR_W-2:0];
            phase_d = in_phase;
            bin_d   = in_bin;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q   <= 1'b0;
            dat_q   <= '0;
            phase_q <= '0;
            bin_q   <= '0;
        end else begin
            vld_q   <= vld_d;
            dat_q   <= dat_d;
            phase_q <= phase_d;
            bin_q   <= bin_d;
        end
    end

    assign m_vld   = vld_q;
    assign m_dat   = dat_q;
    assign m_phase = phase_q;
    assign m_bin   = bin_q;

endmodule

// File: rtl/gps_acq_peak_search.sv
// Reduces a (phase, bin) correlation grid to best/second non-adjacent peaks and a detect flag.
// Latency: last transfer -> done 3 cycles; ready only in ACCUM, never stalls mid-grid.
// GPS_ACQ_NOISE_SUM_EN adds noise_sum (all metrics minus the peak cluster).
module gps_acq_peak_search
    import gps_acq_pkg::*;
#(
    parameter int CORR_W     = 12,
    parameter int PHASE_W    = 10,
    parameter int BIN_W      = 5,
    parameter int MIN_METRIC = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     search_start,
    input  logic                     corr_valid,
    output logic                     corr_ready,
    input  logic [CORR_W-1:0]        corr_value,
    input  logic [PHASE_W-1:0]       corr_phase,
    input  logic [BIN_W-1:0]         corr_bin,
    input  logic                     corr_last,
    output logic                     busy,
    output logic                     done,
    output logic                     detected,
    output logic [CORR_W-2:0]        peak_metric,
    output logic [PHASE_W-1:0]       peak_phase,
    output logic [BIN_W-1:0]         peak_bin,
    output logic [CORR_W-2:0]        second_metric,
    output logic [PHASE_W+BIN_W-1:0] result_count
`ifdef GPS_ACQ_NOISE_SUM_EN
    ,
    output logic [CORR_W+PHASE_W+BIN_W-1:0] noise_sum
`endif
);

    localparam int M_W   = CORR_W - 1;
    localparam int CNT_W = PHASE_W + BIN_W;
    localparam int EW    = CORR_W + 2;

    state_t             state_q, state_d;
    logic [M_W-1:0]     peak_q, peak_d;
    logic [M_W-1:0]     second_q, second_d;
    logic [PHASE_W-1:0] peak_phase_q, peak_phase_d;
    logic [BIN_W-1:0]   peak_bin_q, peak_bin_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               detected_q, detected_d;

    logic               m_vld;
    logic [M_W-1:0]     m_dat;
    logic [PHASE_W-1:0] m_phase;
    logic [BIN_W-1:0]   m_bin;
    logic               xfer;
    logic               adj;
    logic [EW-1:0]      twice_peak;
    logic [EW-1:0]      thrice_second;

    assign corr_ready = (state_q == ST_ACCUM);
    assign xfer       = corr_valid & corr_ready;

    gps_corr_metric #(
        .CORR_W  (CORR_W),
        .PHASE_W (PHASE_W),
        .BIN_W   (BIN_W)
    ) u_metric (
        .clk      (clk),
        .rst      (rst),
        .flush    (search_start),
        .in_vld   (xfer),
        .in_value (corr_value),
        .in_phase (corr_phase),
        .in_bin   (corr_bin),
        .m_vld    (m_vld),
        .m_dat    (m_dat),
        .m_phase  (m_phase),
        .m_bin    (m_bin)
    );

    assign adj = (m_bin == peak_bin_q) &&
                 circ_adjacent(CA_PHASE_W'(m_phase), CA_PHASE_W'(peak_phase_q));

    assign twice_peak    = EW'(peak_q) << 1;
    assign thrice_second = (EW'(second_q) << 1) + EW'(second_q);

    always_comb begin
        state_d      = state_q;
        peak_d       = peak_q;
        second_d     = second_q;
        peak_phase_d = peak_phase_q;
        peak_bin_d   = peak_bin_q;
        count_d      = count_q;
        detected_d   = detected_q;

        unique case (state_q)
            ST_IDLE: ;
            ST_ACCUM: begin
                if (xfer) begin
                    if (count_q != '1) count_d = count_q + 1'b1;
                    if (corr_last) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: state_d = ST_EVAL;
            ST_EVAL: begin
                detected_d = (peak_q >= M_W'(MIN_METRIC)) && (twice_peak >= thrice_second);
                state_d    = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Strict compares: an equal metric never displaces an earlier one.
        if (m_vld) begin
            if (m_dat > peak_q) begin
                if (!adj) second_d = peak_q;
                peak_d       = m_dat;
                peak_phase_d = m_phase;
                peak_bin_d   = m_bin;
            end else if ((m_dat > second_q) && !adj) begin
                second_d = m_dat;
            end
        end

        if (search_start) begin
            state_d      = ST_ACCUM;
            peak_d       = '0;
            second_d     = '0;
            peak_phase_d = '0;
            peak_bin_d   = '0;
            count_d      = '0;
            detected_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            peak_q       <= '0;
            second_q     <= '0;
            peak_phase_q <= '0;
            peak_bin_q   <= '0;
            count_q      <= '0;
            detected_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            peak_q       <= peak_d;
            second_q     <= second_d;
            peak_phase_q <= peak_phase_d;
            peak_bin_q   <= peak_bin_d;
            count_q      <= count_d;
            detected_q   <= detected_d;
        end
    end

    assign busy          = (state_q == ST_ACCUM) || (state_q == ST_FLUSH) || (state_q == ST_EVAL);
    assign done          = (state_q == ST_DONE);
    assign detected      = detected_q;
    assign peak_metric   = peak_q;
    assign peak_phase    = peak_phase_q;
    assign peak_bin      = peak_bin_q;
    assign second_metric = second_q;
    assign result_count  = count_q;

`ifdef GPS_ACQ_NOISE_SUM_EN
    localparam int NW = CORR_W + PHASE_W + BIN_W;

    logic [NW-1:0] total_q, total_d;
    logic [NW-1:0] cluster_q, cluster_d;

    // Cluster sum follows the peak: grows with neighbours, restarts on a distant new peak.
    always_comb begin
        total_d   = total_q;
        cluster_d = cluster_q;
        if (m_vld) begin
            total_d = total_q + NW'(m_dat);
            if (adj) begin
                cluster_d = cluster_q + NW'(m_dat);
            end else if (m_dat > peak_q) begin
                cluster_d = NW'(m_dat);
            end
        end
        if (search_start) begin
            total_d   = '0;
            cluster_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_q   <= '0;
            cluster_q <= '0;
        end else begin
            total_q   <= total_d;
            cluster_q <= cluster_d;
        end
    end

    assign noise_sum = total_q - cluster_q;
`endif

endmodule

// File: tb/tb_gps_acq_peak_search.sv
// Randomized bench for gps_acq_peak_search against a grid-level reference model.
module tb_gps_acq_peak_search;

    localparam int CORR_W  = 12;
    localparam int PHASE_W = 10;
    localparam int BIN_W   = 5;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     search_start;
    logic                     corr_valid;
    logic                     corr_ready;
    logic [CORR_W-1:0]        corr_value;
    logic [PHASE_W-1:0]       corr_phase;
    logic [BIN_W-1:0]         corr_bin;
    logic                     corr_last;
    logic                     busy;
    logic                     done;
    logic                     detected;
    logic [CORR_W-2:0]        peak_metric;
    logic [PHASE_W-1:0]       peak_phase;
    logic [BIN_W-1:0]         peak_bin;
    logic [CORR_W-2:0]        second_metric;
    logic [PHASE_W+BIN_W-1:0] result_count;
`ifdef GPS_ACQ_NOISE_SUM_EN
    logic [CORR_W+PHASE_W+BIN_W-1:0] noise_sum;
`endif

    always #5 clk = ~clk;

    gps_acq_peak_search dut (
        .clk           (clk),
        .rst           (rst_n),
        .search_start  (search_start),
        .corr_valid    (corr_valid),
        .corr_ready    (corr_ready),
        .corr_value    (corr_value),
        .corr_phase    (corr_phase),
        .corr_bin      (corr_bin),
        .corr_last     (corr_last),
        .busy          (busy),
        .done          (done),
        .detected      (detected),
        .peak_metric   (peak_metric),
        .peak_phase    (peak_phase),
        .peak_bin      (peak_bin),
        .second_metric (second_metric),
        .result_count  (result_count)
`ifdef GPS_ACQ_NOISE_SUM_EN
        ,
        .noise_sum     (noise_sum)
`endif
    );

    int total = 0;
    int bad   = 0;

    int q_val[$];
    int q_ph[$];
    int q_bn[$];

    longint exp_peak, exp_phase, exp_bin, exp_second, exp_det, exp_noise;

    int  cyc = 0;
    int  last_cyc = 0;
    int  xfers = 0;
    int  n_done = 0;
    bit  done_seen = 0;
    bit  done_prev = 0;
    bit  held = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic bit ref_adjacent(input int a, input int b);
        int d;
        d = (a - b + 1023) % 1023;
        return (d <= 1) || (d == 1022);
    endfunction

    // Walks the grid in order, applying the peak/second rules directly on integers.
    task automatic model();
        int pk, pph, pbn, sc, tot, cl, m;
        bit adj;
        pk = 0; pph = 0; pbn = 0; sc = 0; tot = 0; cl = 0;
        for (int i = 0; i < q_val.size(); i++) begin
            m = q_val[i] - 2048;
            if (m < 0) m = -m;
            if (m > 2047) m = 2047;
            tot += m;
            adj = (q_bn[i] == pbn) && ref_adjacent(q_ph[i], pph);
            if (adj) cl += m;
            else if (m > pk) cl = m;
            if (m > pk) begin
                if (!adj) sc = pk;
                pk = m; pph = q_ph[i]; pbn = q_bn[i];
            end else if (m > sc && !adj) begin
                sc = m;
            end
        end
        exp_peak   = pk;
        exp_phase  = pph;
        exp_bin    = pbn;
        exp_second = sc;
        exp_det    = (pk >= 64 && 2 * pk >= 3 * sc) ? 1 : 0;
        exp_noise  = tot - cl;
    endtask

    // Compare process: count tracking, done timing/content, and hold-after-done.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            xfers = 0;
            held  = 0;
        end else begin
            if (!search_start) chk("result_count", result_count, xfers);
            if (done) begin
                done_seen = 1;
                n_done++;
                chk("done_pulse_width", done_prev, 0);
                chk("done_latency", cyc - last_cyc, 3);
                chk("busy_at_done", busy, 0);
                chk("peak_metric", peak_metric, exp_peak);
                chk("peak_phase", peak_phase, exp_phase);
                chk("peak_bin", peak_bin, exp_bin);
                chk("second_metric", second_metric, exp_second);
                chk("detected", detected, exp_det);
`ifdef GPS_ACQ_NOISE_SUM_EN
                chk("noise_sum", noise_sum, exp_noise);
`endif
                held = 1;
            end else if (held && !search_start) begin
                chk("hold_peak", peak_metric, exp_peak);
                chk("hold_second", second_metric, exp_second);
                chk("hold_detected", detected, exp_det);
            end
            if (search_start) begin
                xfers = 0;
                held  = 0;
            end else if (corr_valid && corr_ready) begin
                if (xfers < (1 << (PHASE_W + BIN_W)) - 1) xfers++;
                if (corr_last) last_cyc = cyc;
            end
        end
        done_prev = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_grid();
        q_val.delete(); q_ph.delete(); q_bn.delete();
    endtask

    task automatic push(input int v, input int p, input int b);
        q_val.push_back(v); q_ph.push_back(p); q_bn.push_back(b);
    endtask

    task automatic start_search();
        corr_valid   = 1'b0;
        search_start = 1'b1;
        tick();
        search_start = 1'b0;
    endtask

    task automatic send_grid(input int gap_max, input bit with_last);
        int t;
        for (int i = 0; i < q_val.size(); i++) begin
            corr_valid = 1'b0;
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
            corr_valid = 1'b1;
            corr_value = CORR_W'(q_val[i]);
            corr_phase = PHASE_W'(q_ph[i]);
            corr_bin   = BIN_W'(q_bn[i]);
            corr_last  = with_last && (i == q_val.size() - 1);
            t = 0;
            while (!corr_ready && t < 50) begin
                tick();
                t++;
            end
            if (t == 50) begin
                chk("ready_timeout", 0, 1);
                break;
            end
            tick();
        end
        corr_valid = 1'b0;
        corr_last  = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done_seen && t < 20) begin
            tick();
            t++;
        end
        chk("done_arrived", done_seen, 1);
        repeat (3) tick();
    endtask

    task automatic run_case(input int gap_max);
        model();
        done_seen = 0;
        start_search();
        send_grid(gap_max, 1);
        wait_done();
    endtask

    task automatic rand_grid(input int n);
        int base, v, p;
        clear_grid();
        base = $urandom_range(0, 1022);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 14) == 0) v = int'($urandom_range(0, 4095));
            else v = 1948 + int'($urandom_range(0, 200));
            if ($urandom_range(0, 1) == 0) p = int'($urandom_range(0, 1022));
            else p = (base + int'($urandom_range(0, 2))) % 1023;
            push(v, p, int'($urandom_range(0, 7)));
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        rst_n = 1'b0; search_start = 1'b0; corr_valid = 1'b0;
        corr_value = '0; corr_phase = '0; corr_bin = '0; corr_last = 1'b0;
        #1;
        chk("rst_ready", corr_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_detected", detected, 0);
        chk("rst_peak", peak_metric, 0);
        chk("rst_count", result_count, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Single clean spike over a full code period.
        clear_grid();
        for (int p = 0; p < 1023; p++) push((p == 500) ? 2600 : 2048, p, 0);
        run_case(0);
        chk("c1_peak", peak_metric, 552);
        chk("c1_phase", peak_phase, 500);
        chk("c1_second", second_metric, 0);
        chk("c1_det", detected, 1);
        chk("c1_count", result_count, 1023);
`ifdef GPS_ACQ_NOISE_SUM_EN
        chk("c1_noise", noise_sum, 0);
`endif

        // Valid outside ACCUM is ignored.
        corr_valid = 1'b1;
        repeat (4) tick();
        corr_valid = 1'b0;
        chk("idle_ignore", result_count, 1023);

        // Adjacent climb then a distant second.
        clear_grid();
        push(2300, 10, 5); push(2400, 11, 5); push(2200, 700, 3);
        run_case(2);
        chk("c2_peak", peak_metric, 352);
        chk("c2_phase", peak_phase, 11);
        chk("c2_second", second_metric, 152);
        chk("c2_det", detected, 1);

        // Wrap-around adjacency 1022 -> 0.
        clear_grid();
        push(2300, 1022, 4); push(2350, 0, 4);
        run_case(0);
        chk("wrap_peak", peak_metric, 302);
        chk("wrap_phase", peak_phase, 0);
        chk("wrap_second", second_metric, 0);

        // Equal peaks: first kept, ratio test fails.
        clear_grid();
        push(2348, 100, 2); push(2348, 400, 7);
        run_case(1);
        chk("tie_bin", peak_bin, 2);
        chk("tie_second", second_metric, 300);
        chk("tie_det", detected, 0);

        // Everything under the floor.
        clear_grid();
        for (int i = 0; i < 12; i++) push(1990 + int'($urandom_range(0, 116)), i * 80, i % 4);
        run_case(0);
        chk("low_det", detected, 0);

        // Zero count saturates.
        clear_grid();
        push(2100, 40, 1); push(0, 50, 1); push(4095, 900, 6);
        run_case(0);
        chk("sat_peak", peak_metric, 2047);
        chk("sat_second", second_metric, 2047);

        for (int r = 0; r < 8; r++) begin
            rand_grid(20 + int'($urandom_range(0, 130)));
            run_case(r % 3);
        end

        // Abort mid-ACCUM: no done, count restarts.
        nd = n_done;
        rand_grid(15);
        done_seen = 0;
        start_search();
        send_grid(1, 0);
        rand_grid(25);
        model();
        start_search();
        chk("abort_count", result_count, 0);
        chk("abort_busy", busy, 1);
        send_grid(1, 1);
        wait_done();
        chk("abort_one_done", n_done - nd, 1);

        // Reset while in EVAL.
        clear_grid();
        push(2600, 5, 1); push(2100, 300, 2);
        model();
        nd = n_done;
        start_search();
        send_grid(0, 1);
        tick();
        chk("eval_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_eval_busy", busy, 0);
        chk("rst_eval_done", done, 0);
        chk("rst_eval_det", detected, 0);
        chk("rst_eval_peak", peak_metric, 0);
        chk("rst_eval_second", second_metric, 0);
        chk("rst_eval_count", result_count, 0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("rst_eval_no_done", n_done - nd, 0);
        chk("rst_eval_ready", corr_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
